// File: rtl/ov7670_fifo_pkg.sv
// Shared types and default dimensions for the OV7670 + AL422 frame capture/read-out engine.
package ov7670_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WRST,
    WRITE,
    RRST,
    READ,
    DONE
  } fifo_rd_state_t;

  localparam int DEF_H_PIXELS    = 640;
  localparam int DEF_V_LINES     = 480;
  localparam int DEF_RCLK_HALF   = 2;
  localparam int DEF_WRST_CYCLES = 4;

  // Counter width for values 0..limit-1, never narrower than one bit.
  function automatic int clog2_min1(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/ov7670_vsync_edge.sv
// Two-flop synchronizer for the asynchronous camera VSYNC plus a registered rising-edge pulse.
module ov7670_vsync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic sync_q0;
  logic sync_q1;
  logic sync_q2;

  // Pin to rise pulse is three clk edges: two sync flops, then the registered edge compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q0 <= 1'b0;
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q0 <= async_in;
      sync_q1 <= sync_q0;
      sync_q2 <= sync_q1;
      rise    <= sync_q1 & ~sync_q2;
    end
  end

endmodule

// File: rtl/ov7670_fifo_reader.sv
// Captures one camera frame into the AL422 FIFO between two VSYNC edges, then reads it back
// and streams RGB565 pixels downstream.
module ov7670_fifo_reader
  import ov7670_fifo_pkg::*;
#(
  parameter int H_PIXELS    = DEF_H_PIXELS,
  parameter int V_LINES     = DEF_V_LINES,
  parameter int RCLK_HALF   = DEF_RCLK_HALF,
  parameter int WRST_CYCLES = DEF_WRST_CYCLES
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           cam_vsync,
  input  logic [7:0]     cam_data,
  output logic           cam_we,
  output logic           cam_wrst_n,
  output logic           cam_rrst_n,
  output logic           cam_rclk,
  output logic           cam_oe_n,
  output logic [15:0]    pix_data,
  output logic           pix_valid,
  input  logic           pix_ready,
  output logic           pix_sof,
  output logic           pix_eol,
  output logic           busy,
  output logic           frame_done,
  output fifo_rd_state_t dbg_state
);

  localparam int CW = clog2_min1(H_PIXELS);
  localparam int RW = clog2_min1(V_LINES);
  localparam int HW = clog2_min1(RCLK_HALF);
  localparam int WW = clog2_min1(WRST_CYCLES);

  fifo_rd_state_t state;
  logic           vs_rise;
  logic [WW-1:0]  wcnt;
  logic [HW-1:0]  hcnt;
  logic           rst_period;
  logic           byte_odd;
  logic [7:0]     hi_byte;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;

  logic handshake;
  logic last_pix;
  logic half_end;
  logic rclk_run;
  logic sample;

  ov7670_vsync_edge u_vsync_edge (
    .clk      (clk),
    .reset    (reset),
    .async_in (cam_vsync),
    .rise     (vs_rise)
  );

  // Stream: a pixel transfers on any clk edge where pix_valid & pix_ready; pix_valid is
  // registered and, once high, pix_data/pix_sof/pix_eol hold until that transfer happens.
  assign handshake = pix_valid & pix_ready;
  assign last_pix  = (col == CW'(H_PIXELS - 1)) && (row == RW'(V_LINES - 1));
  assign half_end  = (hcnt == HW'(RCLK_HALF - 1));
  // The read clock freezes in its low phase while a pixel waits; it also stops once the
  // final pixel is pending so no byte beyond the frame is clocked out.
  assign rclk_run  = !pix_valid || (pix_ready && !last_pix);
  assign sample    = (state == READ) && rclk_run && cam_rclk && half_end;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cam_we     <= 1'b0;
      cam_wrst_n <= 1'b1;
      cam_rrst_n <= 1'b1;
      cam_rclk   <= 1'b0;
      cam_oe_n   <= 1'b1;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      wcnt       <= '0;
      hcnt       <= '0;
      rst_period <= 1'b0;
      byte_odd   <= 1'b0;
      hi_byte    <= '0;
      col        <= '0;
      row        <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          if (vs_rise) begin
            state      <= WRST;
            cam_wrst_n <= 1'b0;
            wcnt       <= '0;
          end
        end
        WRST: begin
          if (wcnt == WW'(WRST_CYCLES - 1)) begin
            cam_wrst_n <= 1'b1;
            cam_we     <= 1'b1;
            state      <= WRITE;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        WRITE: begin
          if (vs_rise) begin
            cam_we     <= 1'b0;
            cam_oe_n   <= 1'b0;
            cam_rrst_n <= 1'b0;
            cam_rclk   <= 1'b0;
            hcnt       <= '0;
            rst_period <= 1'b0;
            state      <= RRST;
          end
        end
        // Two full read-clock periods with the read pointer held in reset; release lands
        // on a falling edge so the next rising edge presents byte 0.
        RRST: begin
          if (half_end) begin
            hcnt     <= '0;
            cam_rclk <= ~cam_rclk;
            if (cam_rclk) begin
              rst_period <= 1'b1;
              if (rst_period) begin
                cam_rrst_n <= 1'b1;
                byte_odd   <= 1'b0;
                col        <= '0;
                row        <= '0;
                state      <= READ;
              end
            end
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        READ: begin
          if (rclk_run) begin
            if (half_end) begin
              hcnt     <= '0;
              cam_rclk <= ~cam_rclk;
            end else begin
              hcnt <= hcnt + HW'(1);
            end
          end
          if (sample) begin
            byte_odd <= ~byte_odd;
            if (byte_odd) begin
              pix_data  <= {hi_byte, cam_data};
              pix_valid <= 1'b1;
              pix_sof   <= (row == '0) && (col == '0);
              pix_eol   <= (col == CW'(H_PIXELS - 1));
            end else begin
              hi_byte <= cam_data;
            end
          end else if (handshake) begin
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
          end
          if (handshake) begin
            if (col == CW'(H_PIXELS - 1)) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            if (last_pix) begin
              state      <= DONE;
              frame_done <= 1'b1;
              cam_oe_n   <= 1'b1;
              cam_rclk   <= 1'b0;
              hcnt       <= '0;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_fifo_reader.sv
// Bench for ov7670_fifo_reader: AL422 read-port model, stream monitor and per-scenario checks.
module tb_ov7670_fifo_reader;
  import ov7670_fifo_pkg::*;

  localparam int HP     = 4;
  localparam int VL     = 2;
  localparam int RH     = 2;
  localparam int WC     = 4;
  localparam int NPIX   = HP * VL;
  localparam int NBYTES = 2 * NPIX;

  logic           clk       = 1'b0;
  logic           reset     = 1'b1;
  logic           start     = 1'b0;
  logic           cam_vsync = 1'b0;
  logic           pix_ready = 1'b1;
  logic [7:0]     cam_data  = 8'h00;
  logic           cam_we, cam_wrst_n, cam_rrst_n, cam_rclk, cam_oe_n;
  logic [15:0]    pix_data;
  logic           pix_valid, pix_sof, pix_eol, busy, frame_done;
  fifo_rd_state_t dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  mem [NBYTES];
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  int          hs_cyc_q[$];

  int rd_ptr = 0;
  int rd_edges = 0;
  int fd_cnt = 0, fd_cyc = 0;
  int stall_viol = 0, rclk_viol = 0;
  int we_cnt = 0, wrst_cnt = 0, rrst_cnt = 0;
  int wrst_fall_cyc = 0, we_rise_cyc = 0, we_fall_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_word = '0;
  logic        prev_we = 1'b0, prev_wrst_n = 1'b1;

  ov7670_fifo_reader #(
    .H_PIXELS(HP), .V_LINES(VL), .RCLK_HALF(RH), .WRST_CYCLES(WC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cam_vsync(cam_vsync), .cam_data(cam_data),
    .cam_we(cam_we), .cam_wrst_n(cam_wrst_n), .cam_rrst_n(cam_rrst_n), .cam_rclk(cam_rclk),
    .cam_oe_n(cam_oe_n), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy), .frame_done(frame_done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AL422 read port model ----------------
  always @(posedge cam_rclk) begin
    if (!cam_rrst_n) begin
      rd_ptr = 0;
    end else begin
      cam_data = (rd_ptr < NBYTES) ? mem[rd_ptr] : 8'hEE;
      rd_ptr   = rd_ptr + 1;
      rd_edges = rd_edges + 1;
    end
  end

  // ---------------- monitor (mid-cycle) ----------------
  always @(negedge clk) begin
    if (prev_stall && (!pix_valid || {pix_sof, pix_eol, pix_data} !== prev_word))
      stall_viol = stall_viol + 1;
    if (pix_valid && !pix_ready && cam_rclk)
      rclk_viol = rclk_viol + 1;
    prev_stall = pix_valid && !pix_ready;
    prev_word  = {pix_sof, pix_eol, pix_data};
    if (pix_valid && pix_ready) begin
      got_q.push_back({pix_sof, pix_eol, pix_data});
      hs_cyc_q.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc;
    end
    if (cam_we === 1'b1) we_cnt = we_cnt + 1;
    if (cam_wrst_n === 1'b0) wrst_cnt = wrst_cnt + 1;
    if (cam_rrst_n === 1'b0) rrst_cnt = rrst_cnt + 1;
    if (cam_wrst_n === 1'b0 && prev_wrst_n === 1'b1) wrst_fall_cyc = cyc;
    if (cam_we === 1'b1 && prev_we === 1'b0) we_rise_cyc = cyc;
    if (cam_we === 1'b0 && prev_we === 1'b1) we_fall_cyc = cyc;
    prev_we     = cam_we;
    prev_wrst_n = cam_wrst_n;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_vsync(output int c_first);
    c_first   = cyc;
    cam_vsync = 1'b1;
    idle(4);
    cam_vsync = 1'b0;
  endtask

  // Reference frame: pixel k = {byte 2k, byte 2k+1}, sof on pixel 0, eol at each line end.
  task automatic fill_frame(input bit rnd);
    logic [17:0] w;
    logic        s, e;
    for (int i = 0; i < NBYTES; i++) mem[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
    exp_q.delete();
    for (int k = 0; k < NPIX; k++) begin
      s = (k == 0);
      e = ((k % HP) == HP - 1);
      w = {s, e, mem[2 * k], mem[2 * k + 1]};
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_done(input bit stall, output bit ok);
    int base;
    int n;
    base = fd_cnt;
    n = 0;
    while (fd_cnt == base && n < 3000) begin
      pix_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      tick();
      n++;
    end
    pix_ready = 1'b1;
    ok = (fd_cnt != base);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int wb, eb, d;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    wb = wrst_cnt;
    eb = we_cnt;
    idle(20);
    total++; if ({cam_we, cam_wrst_n, cam_rrst_n, cam_rclk, cam_oe_n} !== 5'b01101) begin
      bad++; $display("FAIL reset_cam_pins got=%b want=01101", {cam_we, cam_wrst_n, cam_rrst_n, cam_rclk, cam_oe_n});
    end
    total++; if ({pix_valid, pix_sof, pix_eol, busy, frame_done} !== 5'b00000) begin
      bad++; $display("FAIL reset_flags got=%b want=00000", {pix_valid, pix_sof, pix_eol, busy, frame_done});
    end
    total++; if (pix_data !== 16'h0000) begin
      bad++; $display("FAIL reset_pix_data got=%h want=0000", pix_data);
    end
    total++; if (dbg_state !== IDLE) begin
      bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE);
    end
    pulse_vsync(d);
    idle(6);
    pulse_vsync(d);
    idle(10);
    total++; if (wrst_cnt - wb !== 0 || we_cnt - eb !== 0) begin
      bad++; $display("FAIL idle_vsync_activity got wrst=%0d we=%0d want 0 0", wrst_cnt - wb, we_cnt - eb);
    end
  endtask

  task automatic test_frame();
    int gb, eb, rb, wb, web, fb, c0, c1, dt;
    bit ok;
    fill_frame(1'b0);
    gb = got_q.size(); eb = rd_edges; rb = rrst_cnt; wb = wrst_cnt; web = we_cnt; fb = fd_cnt;
    pulse_start();
    total++; if (busy !== 1'b1 || dbg_state !== ARM) begin
      bad++; $display("FAIL busy_after_start got busy=%b state=%0d want 1 %0d", busy, dbg_state, ARM);
    end
    idle(3);
    pulse_vsync(c0);
    idle(10);
    pulse_vsync(c1);
    wait_done(1'b0, ok);
    idle(2);
    total++; if (ok !== 1'b1) begin
      bad++; $display("FAIL frame_timeout got=%b want=1", ok);
    end
    total++; if (wrst_fall_cyc !== c0 + 4 || wrst_cnt - wb !== WC) begin
      bad++; $display("FAIL wrst_window got start=%0d len=%0d want %0d %0d", wrst_fall_cyc - c0, wrst_cnt - wb, 4, WC);
    end
    total++; if (we_rise_cyc !== c0 + 8 || we_fall_cyc !== c1 + 4 || we_cnt - web !== (c1 + 4) - (c0 + 8)) begin
      bad++; $display("FAIL we_window got rise=%0d fall=%0d len=%0d want %0d %0d %0d",
        we_rise_cyc - c0, we_fall_cyc - c1, we_cnt - web, 8, 4, (c1 + 4) - (c0 + 8));
    end
    total++; if (rrst_cnt - rb !== 4 * RH) begin
      bad++; $display("FAIL rrst_len got=%0d want=%0d", rrst_cnt - rb, 4 * RH);
    end
    total++; if (got_q.size() - gb !== NPIX) begin
      bad++; $display("FAIL frame_pix_count got=%0d want=%0d", got_q.size() - gb, NPIX);
    end
    for (int k = 0; k < NPIX && gb + k < got_q.size(); k++) begin
      total++; if (got_q[gb + k] !== exp_q[k]) begin
        bad++; $display("FAIL frame_pixel[%0d] got=%h want=%h", k, got_q[gb + k], exp_q[k]);
      end
      if (k > 0) begin
        dt = hs_cyc_q[gb + k] - hs_cyc_q[gb + k - 1];
        total++; if (dt !== 4 * RH) begin
          bad++; $display("FAIL pixel_period[%0d] got=%0d want=%0d", k, dt, 4 * RH);
        end
      end
    end
    total++; if (rd_edges - eb !== NBYTES) begin
      bad++; $display("FAIL rclk_read_edges got=%0d want=%0d", rd_edges - eb, NBYTES);
    end
    total++; if (fd_cnt - fb !== 1 || fd_cyc !== hs_cyc_q[hs_cyc_q.size() - 1] + 1) begin
      bad++; $display("FAIL frame_done got count=%0d lag=%0d want 1 1", fd_cnt - fb, fd_cyc - hs_cyc_q[hs_cyc_q.size() - 1]);
    end
    total++; if (busy !== 1'b0 || cam_oe_n !== 1'b1 || dbg_state !== IDLE) begin
      bad++; $display("FAIL frame_end_idle got busy=%b oe_n=%b state=%0d want 0 1 %0d", busy, cam_oe_n, dbg_state, IDLE);
    end
  endtask

  task automatic test_stall();
    int gb, eb, sb, rb, fb, c0, c1;
    bit ok;
    fill_frame(1'b1);
    gb = got_q.size(); eb = rd_edges; sb = stall_viol; rb = rclk_viol; fb = fd_cnt;
    pulse_start();
    idle(3);
    pulse_vsync(c0);
    idle(10);
    pulse_vsync(c1);
    wait_done(1'b1, ok);
    idle(2);
    total++; if (ok !== 1'b1 || got_q.size() - gb !== NPIX) begin
      bad++; $display("FAIL stall_frame got done=%b count=%0d want 1 %0d", ok, got_q.size() - gb, NPIX);
    end
    for (int k = 0; k < NPIX && gb + k < got_q.size(); k++) begin
      total++; if (got_q[gb + k] !== exp_q[k]) begin
        bad++; $display("FAIL stall_pixel[%0d] got=%h want=%h", k, got_q[gb + k], exp_q[k]);
      end
    end
    total++; if (stall_viol - sb !== 0 || rclk_viol - rb !== 0) begin
      bad++; $display("FAIL stall_hold got unstable=%0d rclk_high=%0d want 0 0", stall_viol - sb, rclk_viol - rb);
    end
    total++; if (rd_edges - eb !== NBYTES || fd_cnt - fb !== 1) begin
      bad++; $display("FAIL stall_bytes got edges=%0d done=%0d want %0d 1", rd_edges - eb, fd_cnt - fb, NBYTES);
    end
  endtask

  task automatic test_reset_mid();
    int gb, n, c0, c1;
    bit ok;
    fill_frame(1'b0);
    gb = got_q.size();
    pulse_start();
    idle(3);
    pulse_vsync(c0);
    idle(10);
    pulse_vsync(c1);
    n = 0;
    while (got_q.size() - gb < 3 && n < 2000) begin
      tick();
      n++;
    end
    total++; if (got_q.size() - gb !== 3) begin
      bad++; $display("FAIL mid_reach_pixel3 got=%0d want=3", got_q.size() - gb);
    end
    reset = 1'b1;
    tick();
    total++; if (dbg_state !== IDLE || cam_oe_n !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset got state=%0d oe_n=%b valid=%b busy=%b want %0d 1 0 0",
        dbg_state, cam_oe_n, pix_valid, busy, IDLE);
    end
    reset = 1'b0;
    idle(3);
    gb = got_q.size();
    pulse_start();
    idle(3);
    pulse_vsync(c0);
    idle(10);
    pulse_vsync(c1);
    wait_done(1'b0, ok);
    idle(2);
    total++; if (ok !== 1'b1 || got_q.size() - gb !== NPIX) begin
      bad++; $display("FAIL restart_frame got done=%b count=%0d want 1 %0d", ok, got_q.size() - gb, NPIX);
    end
    total++; if (got_q.size() > gb && got_q[gb] !== 18'h20001) begin
      bad++; $display("FAIL restart_first got=%h want=20001", got_q[gb]);
    end
    for (int k = 1; k < NPIX && gb + k < got_q.size(); k++) begin
      total++; if (got_q[gb + k] !== exp_q[k]) begin
        bad++; $display("FAIL restart_pixel[%0d] got=%h want=%h", k, got_q[gb + k], exp_q[k]);
      end
    end
  endtask

  task automatic test_ignored();
    int gb, fb, n, c0, c1;
    bit ok;
    fill_frame(1'b1);
    gb = got_q.size();
    fb = fd_cnt;
    pulse_start();
    idle(3);
    pulse_vsync(c0);
    idle(9);
    pulse_start();
    total++; if (dbg_state !== WRITE || cam_we !== 1'b1) begin
      bad++; $display("FAIL start_in_write got state=%0d we=%b want %0d 1", dbg_state, cam_we, WRITE);
    end
    idle(3);
    pulse_vsync(c1);
    n = 0;
    while (got_q.size() - gb < 2 && n < 2000) begin
      tick();
      n++;
    end
    cam_vsync = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    idle(3);
    cam_vsync = 1'b0;
    total++; if (dbg_state !== READ) begin
      bad++; $display("FAIL extra_vsync_in_read got state=%0d want %0d", dbg_state, READ);
    end
    wait_done(1'b0, ok);
    idle(4);
    total++; if (ok !== 1'b1 || got_q.size() - gb !== NPIX || fd_cnt - fb !== 1) begin
      bad++; $display("FAIL ignored_events got done=%b count=%0d fd=%0d want 1 %0d 1",
        ok, got_q.size() - gb, fd_cnt - fb, NPIX);
    end
    for (int k = 0; k < NPIX && gb + k < got_q.size(); k++) begin
      total++; if (got_q[gb + k] !== exp_q[k]) begin
        bad++; $display("FAIL ignored_pixel[%0d] got=%h want=%h", k, got_q[gb + k], exp_q[k]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_reset_mid();
    test_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
